// File: rtl/vpu_pkg.sv
// Shared definitions for the VPU command scheduler: FSM encoding, command field layout.
package vpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } vpu_state_e;

  localparam int CTRL_W = 19;
  localparam int VEC_W  = 144;
  localparam int CMD_W  = CTRL_W + VEC_W;

  localparam int OBJ_NUM_LSB   = 0;
  localparam int OBJ_NUM_W     = 5;
  localparam int CODE_LSB      = 5;
  localparam int CODE_W        = 4;
  localparam int OP_LSB        = 9;
  localparam int OP_W          = 4;
  localparam int OBJ_COLOR_LSB = 13;
  localparam int OBJ_COLOR_W   = 3;
  localparam int OBJ_TYPE_LSB  = 16;
  localparam int OBJ_TYPE_W    = 2;
  localparam int FILL_LSB      = 18;

  localparam int LANE_W    = 16;
  localparam int NUM_LANES = 8;
  localparam int RO_LSB    = NUM_LANES * LANE_W;

  function automatic logic [LANE_W-1:0] vec_lane(input logic [VEC_W-1:0] vec, input int idx);
    return vec[idx*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/vpu_cmd_fifo.sv
// Command queue: register array with wrapping pointers and a registered level/full pair.
module vpu_cmd_fifo
  import vpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [4:0]       level,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [4:0]       lvl_nxt;

  // A push against a full queue is dropped even if a pop frees a slot this cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && (level != 5'd0) && !flush;
  assign dout    = mem[rd_ptr];

  always_comb begin
    lvl_nxt = level;
    if (flush) begin
      lvl_nxt = 5'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   lvl_nxt = level + 5'd1;
        2'b01:   lvl_nxt = level - 5'd1;
        default: lvl_nxt = level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 5'd0;
      full   <= 1'b0;
    end else begin
      level <= lvl_nxt;
      full  <= (lvl_nxt == 5'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vpu_cmd_sched.sv
// Queues CPU commands and hands them one at a time to the VPU, tracking ack/done and result writes.
//   state        | meaning
//   ST_IDLE      | nothing in flight; wait for a queued command and VPU_rdy
//   ST_ISSUE     | pop head, drive it to the VPU, pulse start_VPU
//   ST_WAIT_ACK  | wait for VPU_rdy to fall, bounded by ACK_TIMEOUT
//   ST_WAIT_DONE | VPU working; VPU_rdy rising ends the command
module vpu_cmd_sched
  import vpu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [CTRL_W-1:0] cmd_ctrl,
  input  logic [VEC_W-1:0]  cmd_vec,
  input  logic              flush,
  input  logic              VPU_rdy,
  input  logic              VPU_data_we,
  output logic              cmd_full,
  output logic [4:0]        level,
  output logic              start_VPU,
  output logic [CTRL_W-1:0] ctrl_VPU,
  output logic [VEC_W-1:0]  vec_VPU,
  output logic              busy,
  output logic [7:0]        result_cnt
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  vpu_state_e       state;
  vpu_state_e       state_nxt;
  logic [CMD_W-1:0] head;
  logic [TW-1:0]    ack_tmr;
  logic             issue;
  logic             done;

  vpu_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .pop   (issue),
    .flush (flush),
    .din   ({cmd_ctrl, cmd_vec}),
    .dout  (head),
    .level (level),
    .full  (cmd_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A flush in the deciding cycle must not let a discarded head be issued.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (level != 5'd0 && VPU_rdy && !flush) state_nxt = ST_ISSUE;
      ST_ISSUE:     state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (!VPU_rdy)            state_nxt = ST_WAIT_DONE;
        else if (ack_tmr == '0)  state_nxt = ST_IDLE;
      end
      ST_WAIT_DONE: if (VPU_rdy) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    issue = (state == ST_ISSUE);
    done  = (state == ST_WAIT_ACK || state == ST_WAIT_DONE) && (state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_VPU  <= 1'b0;
      ctrl_VPU   <= '0;
      vec_VPU    <= '0;
      busy       <= 1'b0;
      result_cnt <= 8'd0;
      ack_tmr    <= '0;
    end else begin
      start_VPU <= issue;
      if (issue) begin
        ctrl_VPU <= head[CMD_W-1:VEC_W];
        vec_VPU  <= head[VEC_W-1:0];
        ack_tmr  <= TW'(ACK_TIMEOUT - 1);
      end else if (state == ST_WAIT_ACK && ack_tmr != '0) begin
        ack_tmr <= ack_tmr - 1'b1;
      end
      if (issue)     busy <= 1'b1;
      else if (done) busy <= 1'b0;
      if (issue)
        result_cnt <= 8'd0;
      else if (busy && VPU_data_we && result_cnt != 8'hFF)
        result_cnt <= result_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vpu_cmd_sched.sv
// Directed bench for vpu_cmd_sched with a queue-based reference model checked every cycle.
module tb_vpu_cmd_sched;
  import vpu_pkg::*;

  localparam int DEPTH       = 4;
  localparam int ACK_TIMEOUT = 4;

  localparam int M_IDLE  = 0;
  localparam int M_SCHED = 1;
  localparam int M_ACK   = 2;
  localparam int M_DONE  = 3;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic [CTRL_W-1:0] cmd_ctrl;
  logic [VEC_W-1:0]  cmd_vec;
  logic              flush;
  logic              VPU_rdy;
  logic              VPU_data_we;
  logic              cmd_full;
  logic [4:0]        level;
  logic              start_VPU;
  logic [CTRL_W-1:0] ctrl_VPU;
  logic [VEC_W-1:0]  vec_VPU;
  logic              busy;
  logic [7:0]        result_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [CMD_W-1:0]  mq[$];
  int                m_mode;
  int                m_ack;
  logic              m_start;
  logic              m_busy;
  logic [7:0]        m_cnt;
  logic [CTRL_W-1:0] m_ctrl;
  logic [VEC_W-1:0]  m_vec;

  vpu_cmd_sched #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ctrl    (cmd_ctrl),
    .cmd_vec     (cmd_vec),
    .flush       (flush),
    .VPU_rdy     (VPU_rdy),
    .VPU_data_we (VPU_data_we),
    .cmd_full    (cmd_full),
    .level       (level),
    .start_VPU   (start_VPU),
    .ctrl_VPU    (ctrl_VPU),
    .vec_VPU     (vec_VPU),
    .busy        (busy),
    .result_cnt  (result_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode  = M_IDLE;
    m_ack   = 0;
    m_start = 1'b0;
    m_busy  = 1'b0;
    m_cnt   = 8'd0;
    m_ctrl  = '0;
    m_vec   = '0;
  endtask

  // One clock edge of the reference: command list, issue handshake, result counter.
  task automatic model_step();
    bit was_full;
    bit was_busy;
    int mode_old;
    was_full = (mq.size() == DEPTH);
    was_busy = m_busy;
    mode_old = m_mode;
    m_start  = 1'b0;
    if (was_busy && VPU_data_we && m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
    case (mode_old)
      M_IDLE: if (mq.size() != 0 && VPU_rdy && !flush) m_mode = M_SCHED;
      M_SCHED: begin
        {m_ctrl, m_vec} = mq.pop_front();
        m_start = 1'b1;
        m_busy  = 1'b1;
        m_cnt   = 8'd0;
        m_ack   = 0;
        m_mode  = M_ACK;
      end
      M_ACK: begin
        if (!VPU_rdy) m_mode = M_DONE;
        else begin
          m_ack++;
          if (m_ack == ACK_TIMEOUT) begin
            m_mode = M_IDLE;
            m_busy = 1'b0;
          end
        end
      end
      default: if (VPU_rdy) begin
        m_mode = M_IDLE;
        m_busy = 1'b0;
      end
    endcase
    if (flush) mq.delete();
    else if (cmd_valid && !was_full) mq.push_back({cmd_ctrl, cmd_vec});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("start_VPU", VEC_W'(start_VPU), VEC_W'(m_start));
      chk("busy", VEC_W'(busy), VEC_W'(m_busy));
      chk("level", VEC_W'(level), VEC_W'(mq.size()));
      chk("cmd_full", VEC_W'(cmd_full), VEC_W'(mq.size() == DEPTH));
      chk("result_cnt", VEC_W'(result_cnt), VEC_W'(m_cnt));
      chk("ctrl_VPU", VEC_W'(ctrl_VPU), VEC_W'(m_ctrl));
      chk("vec_VPU", vec_VPU, m_vec);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_lvl[5];
    logic [VEC_W-1:0] v;
    exp_lvl = '{1, 2, 3, 4, 4};
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_ctrl = '0; cmd_vec = '0;
    flush = 1'b0; VPU_rdy = 1'b0; VPU_data_we = 1'b0;
    repeat (3) tick();
    chk("rst_busy", VEC_W'(busy), '0);
    chk("rst_level", VEC_W'(level), '0);
    rst_n = 1'b1;
    VPU_rdy = 1'b1;
    tick();

    // single command, VPU stays ready: issue two edges after the push
    v = '0; v[15:0] = 16'hABCD;
    cmd_valid = 1'b1; cmd_ctrl = 19'h1_2345; cmd_vec = v;
    tick();
    cmd_valid = 1'b0;
    chk("t1_start_e1", VEC_W'(start_VPU), '0);
    chk("t1_level_e1", VEC_W'(level), VEC_W'(1));
    tick();
    chk("t1_start_e2", VEC_W'(start_VPU), '0);
    tick();
    chk("t1_start_e3", VEC_W'(start_VPU), VEC_W'(1));
    chk("t1_busy", VEC_W'(busy), VEC_W'(1));
    chk("t1_v0", VEC_W'(vec_lane(vec_VPU, 0)), VEC_W'(16'hABCD));
    chk("t1_ctrl", VEC_W'(ctrl_VPU), VEC_W'(19'h1_2345));
    chk("t1_level_e3", VEC_W'(level), '0);

    // second command queued behind; ack timeout frees the scheduler
    v = '0; v[143:128] = 16'h5A5A;
    cmd_valid = 1'b1; cmd_ctrl = 19'h0_0F0F; cmd_vec = v;
    tick();
    cmd_valid = 1'b0;
    n = 1;
    while (start_VPU !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t2_reissue_gap", VEC_W'(n), VEC_W'(6));
    chk("t2_ctrl", VEC_W'(ctrl_VPU), VEC_W'(19'h0_0F0F));
    chk("t2_ro", VEC_W'(vec_VPU[143:128]), VEC_W'(16'h5A5A));

    // result writes during WAIT_DONE, then one while idle
    VPU_rdy = 1'b0;
    tick();
    VPU_data_we = 1'b1;
    repeat (3) tick();
    VPU_data_we = 1'b0;
    VPU_rdy = 1'b1;
    tick();
    chk("t3_cnt", VEC_W'(result_cnt), VEC_W'(3));
    chk("t3_busy", VEC_W'(busy), '0);
    VPU_data_we = 1'b1;
    tick();
    VPU_data_we = 1'b0;
    tick();
    chk("t3_cnt_idle", VEC_W'(result_cnt), VEC_W'(3));

    // fill the queue with the VPU held busy; fifth push is dropped
    VPU_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_ctrl = 19'h100 + 19'(i); cmd_vec = VEC_W'(i + 7);
      tick();
      chk("t4_level", VEC_W'(level), VEC_W'(exp_lvl[i]));
      chk("t4_full", VEC_W'(cmd_full), VEC_W'(i >= 3));
    end
    cmd_valid = 1'b0;
    chk("t4_no_start", VEC_W'(start_VPU), '0);

    // flush with one in flight and three queued
    VPU_rdy = 1'b1;
    tick();
    tick();
    chk("t5_start", VEC_W'(start_VPU), VEC_W'(1));
    chk("t5_level", VEC_W'(level), VEC_W'(3));
    chk("t5_ctrl", VEC_W'(ctrl_VPU), VEC_W'(19'h100));
    VPU_rdy = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_level_flush", VEC_W'(level), '0);
    chk("t5_busy_flush", VEC_W'(busy), VEC_W'(1));
    VPU_rdy = 1'b1;
    tick();
    chk("t5_done", VEC_W'(busy), '0);
    n = 0;
    repeat (12) begin
      tick();
      if (start_VPU === 1'b1) n++;
    end
    chk("t5_no_more_starts", VEC_W'(n), '0);

    // async reset in WAIT_DONE
    cmd_valid = 1'b1; cmd_ctrl = 19'h7_1111; cmd_vec = VEC_W'(16'h1111);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    VPU_rdy = 1'b0;
    tick();
    cmd_valid = 1'b1; cmd_ctrl = 19'h2_2222;
    tick();
    cmd_ctrl = 19'h3_3333;
    tick();
    cmd_valid = 1'b0;
    VPU_data_we = 1'b1;
    tick();
    VPU_data_we = 1'b0;
    chk("t6_pre_busy", VEC_W'(busy), VEC_W'(1));
    chk("t6_pre_level", VEC_W'(level), VEC_W'(2));
    chk("t6_pre_cnt", VEC_W'(result_cnt), VEC_W'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", VEC_W'(busy), '0);
    chk("t6_level", VEC_W'(level), '0);
    chk("t6_cnt", VEC_W'(result_cnt), '0);
    chk("t6_ctrl", VEC_W'(ctrl_VPU), '0);
    chk("t6_vec", vec_VPU, '0);
    chk("t6_full", VEC_W'(cmd_full), '0);
    chk("t6_start", VEC_W'(start_VPU), '0);
    tick();
    rst_n = 1'b1;
    VPU_rdy = 1'b1;
    repeat (4) tick();
    chk("t6_post_level", VEC_W'(level), '0);
    chk("t6_post_busy", VEC_W'(busy), '0);

    // result counter saturation
    cmd_valid = 1'b1; cmd_ctrl = 19'h4_4444; cmd_vec = '0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    VPU_rdy = 1'b0;
    tick();
    VPU_data_we = 1'b1;
    repeat (260) tick();
    VPU_data_we = 1'b0;
    chk("t7_sat", VEC_W'(result_cnt), VEC_W'(255));
    VPU_rdy = 1'b1;
    tick();
    chk("t7_done", VEC_W'(busy), '0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vpu_cmd_sched.md
VPU_CMD_SCHED -- requirements
Module: vpu_cmd_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, 2..16): command queue entries.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 4: cycles to wait for VPU_rdy to fall after issue.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock; rst_n  in  1  reset.
REQ-004 SHALL have port cmd_valid  in  1  CPU push request, sampled on the rising edge of clk.
REQ-005 SHALL have port cmd_ctrl  in  19  packed fields {fill[18], obj_type[17:16], obj_color[15:13], op[12:9], code[8:5], obj_num[4:0]}.
REQ-006 SHALL have port cmd_vec  in  144  packed V0[15:0], V1[31:16] ... V7[127:112], RO[143:128].
REQ-007 SHALL have port flush  in  1  discards queued, not-yet-issued commands.
REQ-008 SHALL have port VPU_rdy  in  1  VPU idle indicator.
REQ-009 SHALL have port VPU_data_we  in  1  VPU result-write strobe.
REQ-010 SHALL have port cmd_full  out  1  queue full; CPU stalls.
REQ-011 SHALL have port level  out  5  queued entries, excluding the in-flight entry.
REQ-012 SHALL have port start_VPU  out  1  single-cycle issue pulse.
REQ-013 SHALL have ports ctrl_VPU (out, 19) and vec_VPU (out, 144), laid out as REQ-005 and REQ-006.
REQ-014 SHALL have port busy  out  1  a command is in flight.
REQ-015 SHALL have port result_cnt  out  8  VPU_data_we pulses seen for the current command.

Function
REQ-016 SHALL push {cmd_ctrl, cmd_vec} when cmd_valid=1 and cmd_full=0; a push while cmd_full=1 SHALL be dropped, even if a pop occurs in the same cycle.
REQ-017 SHALL drive cmd_full=1 exactly when level==DEPTH; cmd_full and level SHALL be registered.
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-019 SHALL go IDLE->ISSUE when the queue is non-empty and VPU_rdy=1.
REQ-020 SHALL, in ISSUE, assert start_VPU for one cycle, register the head entry onto ctrl_VPU/vec_VPU, pop the head, clear result_cnt, set busy, and go to WAIT_ACK.
REQ-021 SHALL leave ctrl_VPU/vec_VPU stable from issue until the next ISSUE.
REQ-022 SHALL, in WAIT_ACK, go to WAIT_DONE when VPU_rdy=0; if VPU_rdy stays 1 for ACK_TIMEOUT cycles, it SHALL treat the command as complete and go to IDLE.
REQ-023 SHALL, in WAIT_DONE, go to IDLE and clear busy on the first cycle VPU_rdy=1.
REQ-024 SHALL make start_VPU rise no earlier than the second clock edge after a push into an empty queue with the FSM in IDLE and VPU_rdy=1 (minimum 2-cycle latency).
REQ-025 SHALL increment result_cnt, saturating at 255, on each VPU_data_we while busy=1, and ignore VPU_data_we while busy=0.
REQ-026 SHALL, on flush, empty the queue (level=0 next cycle) without affecting the in-flight command or the FSM state.
REQ-027 SHALL, on a simultaneous flush and push, complete the flush and drop the push.
REQ-028 SHALL wrap the read and write pointers modulo DEPTH.
REQ-029 SHALL net level +1 on a push, -1 on a pop, and 0 on a simultaneous push and pop.

Reset
REQ-030 SHALL, on rst_n=0 and asynchronously at any point including mid-command, go to IDLE, empty the queue, and drive start_VPU=0, busy=0, cmd_full=0, level=0, result_cnt=0, ctrl_VPU=0, vec_VPU=0.
REQ-031 SHALL not issue a command before the second rising edge of clk after rst_n is released.

Structure
REQ-032 SHALL place the FSM state encoding, the ctrl field offsets and widths, and the vec lane offsets in shared package vpu_pkg.
REQ-033 SHALL implement the queue storage as sub-module vpu_cmd_fifo (synchronous-write register array with pointers); the FSM, timeout counter and result counter SHALL reside in the top module.

Verification
REQ-034 SHALL cover: one push (ctrl=19'h1_2345, V0=16'hABCD) with VPU_rdy=1 -> start_VPU pulse within 2 cycles, vec_VPU[15:0]=16'hABCD, busy=1.
REQ-035 SHALL cover: 5 back-to-back pushes with VPU_rdy=0, DEPTH=4 -> cmd_full=1 after the 4th push, the 5th is dropped, level=4.
REQ-036 SHALL cover: VPU_rdy stays 1 after issue -> return to IDLE after 4 cycles, next command issues.
REQ-037 SHALL cover: 3 VPU_data_we pulses during WAIT_DONE -> result_cnt=3; one pulse while idle -> result_cnt unchanged.
REQ-038 SHALL cover: flush with level=3 and one command in flight -> level=0, in-flight command completes, no further start_VPU.
REQ-039 SHALL cover: rst_n=0 during WAIT_DONE -> all outputs 0 immediately, FSM in IDLE, queue empty.
